// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR next_dv sequencer.
// Optional overrun counters are enabled by FIR_SEQ_OVERRUN_EN.
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } seq_state_t;

  localparam int SEQ_MIN_DIV = 1;
  localparam int OVR_CNT_W   = 16;

endpackage

// File: rtl/fir_dv_sequencer_if.sv
// Config, source-valid and FIR-control bundle of the sequencer.
// FIR_SEQ_OVERRUN_EN adds the ovr_flag / ovr_count signals.
interface fir_dv_sequencer_if #(
  parameter int DIV_WIDTH = 16
);

  logic [DIV_WIDTH-1:0] cfg_div;
  logic                 cfg_load;
  logic                 src_tvalid;
  logic                 next_dv;
  logic                 fir_tvalid;
  logic                 out_tvalid;
  logic [1:0]           seq_state;
`ifdef FIR_SEQ_OVERRUN_EN
  logic                 ovr_flag;
  logic [fir_seq_pkg::OVR_CNT_W-1:0] ovr_count;

  modport master (
    output cfg_div, cfg_load, src_tvalid,
    input  next_dv, fir_tvalid, out_tvalid,
    input  seq_state, ovr_flag, ovr_count
  );

  modport slave (
    input  cfg_div, cfg_load, src_tvalid,
    output next_dv, fir_tvalid, out_tvalid,
    output seq_state, ovr_flag, ovr_count
  );
`else
  modport master (
    output cfg_div, cfg_load, src_tvalid,
    input  next_dv, fir_tvalid, out_tvalid,
    input  seq_state
  );

  modport slave (
    input  cfg_div, cfg_load, src_tvalid,
    output next_dv, fir_tvalid, out_tvalid,
    output seq_state
  );
`endif

endinterface

// File: rtl/fir_dv_strobe_gen.sv
// Programmable prescaler producing the one-cycle next_dv strobe
// and the tick on its falling edge.
module fir_dv_strobe_gen
  import fir_seq_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 a_clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_load,
  output logic                 next_dv,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(SEQ_MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_clamp;

  assign div_clamp = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      div_reg <= MIN_DIV;
      cnt     <= '0;
      next_dv <= 1'b0;
    end else if (cfg_load) begin
      div_reg <= div_clamp;
      cnt     <= '0;
      next_dv <= 1'b0;
    end else if (cnt == div_reg) begin
      cnt     <= '0;
      next_dv <= 1'b1;
    end else begin
      cnt     <= cnt + ONE;
      next_dv <= 1'b0;
    end
  end

  // Edge where next_dv falls; a coincident load wins.
  assign tick = next_dv & ~cfg_load;

endmodule

// File: rtl/fir_dv_sequencer.sv
// Sequences flush / fill / run of the boxcar FIR on next_dv ticks.
// FIR_SEQ_OVERRUN_EN adds sticky overrun flag and counter.
module fir_dv_sequencer
  import fir_seq_pkg::*;
#(
  parameter int FIR_DECI   = 64,
  parameter int FIR_DECI_L = 6,
  parameter int DIV_WIDTH  = 16
) (
  input logic               a_clk,
  input logic               reset,
  fir_dv_sequencer_if.slave bus
);

  localparam int CW = FIR_DECI_L + 1;
  localparam logic [CW-1:0] WIN  = CW'(FIR_DECI);
  localparam logic [CW-1:0] ONE  = CW'(1);

  seq_state_t    state, state_n;
  logic [CW-1:0] scnt, scnt_n, scnt_inc;
  logic          fir_q, fir_n;
  logic          out_q, out_n;
  logic          tick;

  fir_dv_strobe_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_strobe (
    .a_clk   (a_clk),
    .reset   (reset),
    .cfg_div (bus.cfg_div),
    .cfg_load(bus.cfg_load),
    .next_dv (bus.next_dv),
    .tick    (tick)
  );

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      scnt  <= '0;
      fir_q <= 1'b0;
      out_q <= 1'b0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      fir_q <= fir_n;
      out_q <= out_n;
    end
  end

  always_comb begin
    state_n  = state;
    scnt_n   = scnt;
    fir_n    = fir_q;
    out_n    = out_q;
    scnt_inc = scnt + ONE;
    if (bus.cfg_load) begin
      state_n = IDLE;
      scnt_n  = '0;
      fir_n   = 1'b0;
      out_n   = 1'b0;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          fir_n = 1'b0;
          out_n = 1'b0;
          if (bus.src_tvalid) begin
            state_n = FLUSH;
            scnt_n  = '0;
          end
        end
        FLUSH: begin
          fir_n  = 1'b0;
          out_n  = 1'b0;
          scnt_n = scnt_inc;
          // Flush always completes; source decides where it lands.
          if (scnt_inc == WIN) begin
            scnt_n  = '0;
            state_n = bus.src_tvalid ? FILL : IDLE;
            fir_n   = bus.src_tvalid;
          end
        end
        FILL: begin
          if (!bus.src_tvalid) begin
            state_n = IDLE;
            fir_n   = 1'b0;
            out_n   = 1'b0;
          end else begin
            scnt_n = scnt_inc;
            if (scnt_inc == WIN) begin
              state_n = RUN;
              out_n   = 1'b1;
            end
          end
        end
        RUN: begin
          if (!bus.src_tvalid) begin
            state_n = IDLE;
            fir_n   = 1'b0;
            out_n   = 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.fir_tvalid = fir_q;
  assign bus.out_tvalid = out_q;
  assign bus.seq_state  = state;

`ifdef FIR_SEQ_OVERRUN_EN
  logic                 ovr_evt;
  logic                 ovr_flag_q;
  logic [OVR_CNT_W-1:0] ovr_cnt_q;

  assign ovr_evt = tick & (state == RUN) & ~bus.src_tvalid;

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      ovr_flag_q <= 1'b0;
      ovr_cnt_q  <= '0;
    end else if (bus.cfg_load) begin
      ovr_flag_q <= 1'b0;
      ovr_cnt_q  <= '0;
    end else if (ovr_evt) begin
      ovr_flag_q <= 1'b1;
      if (ovr_cnt_q != '1)
        ovr_cnt_q <= ovr_cnt_q + OVR_CNT_W'(1);
    end
  end

  assign bus.ovr_flag  = ovr_flag_q;
  assign bus.ovr_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_fir_dv_sequencer.sv
// Directed bench for fir_dv_sequencer: vector table plus
// hand-written multi-cycle sequences (FIR_DECI=64).
module tb_fir_dv_sequencer;
  import fir_seq_pkg::*;

  logic a_clk = 1'b0;
  logic reset;
  always #5 a_clk = ~a_clk;

  fir_dv_sequencer_if #(.DIV_WIDTH(16)) bus ();

  fir_dv_sequencer #(
    .FIR_DECI  (64),
    .FIR_DECI_L(6),
    .DIV_WIDTH (16)
  ) dut (
    .a_clk(a_clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int viol   = 0;
  logic pdv  = 1'b0;
  logic pfir = 1'b0;

  // fir_tvalid must hold on every edge where next_dv rises
  always @(posedge a_clk) begin
    #1;
    if (!reset && bus.next_dv && !pdv && bus.fir_tvalid !== pfir)
      viol++;
    pdv  = bus.next_dv;
    pfir = bus.fir_tvalid;
  end

  typedef struct {
    logic        load;
    logic [15:0] div;
    logic        src;
    logic        dv;
    logic [1:0]  st;
    logic        fir;
    logic        out;
  } vec_t;

  vec_t tv[14];

  task automatic step();
    @(posedge a_clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget,
                            input string name);
    int n;
    n = 0;
    while (bus.seq_state !== s && n < budget) begin
      step();
      n++;
    end
    check(name, {30'd0, bus.seq_state}, {30'd0, s});
  endtask

  task automatic wait_dv(input int budget, input string name);
    int n;
    n = 0;
    while (bus.next_dv !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(name, {31'd0, bus.next_dv}, 32'd1);
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, bus.next_dv, bus.seq_state, bus.fir_tvalid,
            bus.out_tvalid};
  endfunction

  initial begin
    int tf;
    int c1;
    logic [5:0] pat;

    tv[0]  = '{1'b1, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 16'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 16'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 16'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 16'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 16'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 16'd2, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[10] = '{1'b0, 16'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tv[11] = '{1'b0, 16'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tv[12] = '{1'b0, 16'd2, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tv[13] = '{1'b0, 16'd2, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};

    reset          = 1'b1;
    bus.cfg_div    = '0;
    bus.cfg_load   = 1'b0;
    bus.src_tvalid = 1'b0;
    step();
    step();
    check("reset_outs", outs(), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      bus.cfg_load   = tv[i].load;
      bus.cfg_div    = tv[i].div;
      bus.src_tvalid = tv[i].src;
      step();
      check($sformatf("vec%0d", i), outs(),
            {27'd0, tv[i].dv, tv[i].st, tv[i].fir, tv[i].out});
    end
    bus.cfg_load = 1'b0;

    // period 5, full flush/fill latency
    bus.cfg_div  = 16'd4;
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    check("load_idle", outs(), 32'd0);
    wait_dv(10, "first_dv");
    c1 = cyc;
    step();
    tf = cyc;
    check("dv_one_cycle_flush", outs(), {27'd0, 1'b0, 2'd1, 2'b00});
    wait_dv(10, "second_dv");
    check("period5", cyc - c1, 32'd5);
    wait_state(2'd2, 400, "reach_fill");
    check("flush_len", cyc - tf, 32'd320);
    check("fill_fir", {31'd0, bus.fir_tvalid}, 32'd1);
    wait_state(2'd3, 400, "reach_run");
    check("run_latency", cyc - tf, 32'd640);
    check("run_outs", {30'd0, bus.fir_tvalid, bus.out_tvalid}, 32'd3);

    // source loss just before a strobe
    wait_dv(10, "loss_dv0");
    step();
    bus.src_tvalid = 1'b0;
    wait_dv(10, "loss_dv1");
    check("loss_pre", outs(), {27'd0, 1'b1, 2'd3, 2'b11});
    step();
    check("loss_tick", outs(), {27'd0, 1'b0, 2'd0, 2'b00});
    bus.src_tvalid = 1'b1;
    wait_state(2'd1, 10, "reflush");
    tf = cyc;
    wait_state(2'd2, 400, "refill");
    check("reflush_len", cyc - tf, 32'd320);

    // cfg_load coincident with a strobe in FILL
    wait_dv(10, "cfg_dv");
    for (int i = 0; i < 4; i++) step();
    check("cfg_pre", outs(), {27'd0, 1'b0, 2'd2, 2'b10});
    bus.cfg_div  = 16'd2;
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    check("cfg_edge", outs(), 32'd0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      pat[i] = bus.next_dv;
    end
    check("cfg_newper", {28'd0, pat[3:0]}, 32'b0100);
    check("cfg_flush", {30'd0, bus.seq_state}, 32'd1);

    // clamp: cfg_div=0 -> period 2
    bus.cfg_div  = 16'd0;
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      pat[i] = bus.next_dv;
    end
    check("clamp_alt", {26'd0, pat}, 32'b101010);
    wait_state(2'd3, 600, "clamp_run");
    check("clamp_out", {31'd0, bus.out_tvalid}, 32'd1);

    // asynchronous reset mid-period
    step();
    #2 reset = 1'b1;
    #1 check("async_rst", outs(), 32'd0);
    step();
    reset = 1'b0;
    check("rst_hold", outs(), 32'd0);

`ifdef FIR_SEQ_OVERRUN_EN
    check("ovr_rst", {15'd0, bus.ovr_flag, bus.ovr_count}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.src_tvalid = 1'b1;
      wait_state(2'd3, 700, "ovr_run");
      bus.src_tvalid = 1'b0;
      wait_state(2'd0, 10, "ovr_idle");
    end
    check("ovr_cnt3", {15'd0, bus.ovr_flag, bus.ovr_count},
          {15'd0, 1'b1, 16'd3});
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    check("ovr_clr", {15'd0, bus.ovr_flag, bus.ovr_count}, 32'd0);
`endif

    step();
    check("fir_stable_on_strobe", viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
